irrigation_actuator_sequencer: RTL and testbench

Registered output stage between the combinational irrigation decision logic and the physical actuators. It consumes the raw requests for the sprinkler pump, dripper valve and water-supply valve, plus the level-sensor alarm. It drives the actuators with these guarantees:
- minimum on-times and minimum off-times;
- sprinkler and dripper are never on together;
- alarm shutdown is latched and held before restart.

---
 rtl/irrigation_pkg.sv | 42 ++++
 rtl/irrigation_actuator_sequencer_dwell_counter.sv | 40 ++++
 rtl/irrigation_actuator_sequencer.sv | 142 ++++++++++++++
 tb/tb_irrigation_actuator_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// irrigation_pkg
// Shared definitions for the irrigation actuator stages.
//   irr_state_t           : sequencer state set (IDLE, SPRINKLE, DRIP, GAP, LOCKOUT)
//   DEFAULT_* constants   : default dwell times, reused by other timed stages
//   max3 / dwell_width    : helpers that size a dwell counter able to hold the
//                           largest of three dwell thresholds
// -----------------------------------------------------------------------------
package irrigation_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPRINKLE,
        DRIP,
        GAP,
        LOCKOUT
    } irr_state_t;

    localparam int DEFAULT_MIN_ON_CYCLES     = 8;
    localparam int DEFAULT_MIN_OFF_CYCLES    = 4;
    localparam int DEFAULT_ALARM_HOLD_CYCLES = 16;

    // Largest of three dwell thresholds.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One extra bit above $clog2 so the counter can reach the largest
    // threshold itself (the lockout hold compares against the full value).
    function automatic int dwell_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c)) + 1;
    endfunction

    localparam int DEFAULT_DWELL_WIDTH =
        dwell_width(DEFAULT_MIN_ON_CYCLES, DEFAULT_MIN_OFF_CYCLES, DEFAULT_ALARM_HOLD_CYCLES);

endpackage

// File: rtl/irrigation_actuator_sequencer_dwell_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dwell_counter
// Clear/enable counter that saturates at all-ones, with an unsigned
// "reached" compare against a threshold supplied at run time.
//   clock     : system clock
//   reset_n   : synchronous active-low reset, clears the count
//   clear     : synchronous clear, has priority over enable
//   enable    : advance the count by one (held once saturated)
//   threshold : run-time compare value
//   reached   : count >= threshold
// -----------------------------------------------------------------------------
module dwell_counter
    import irrigation_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DWELL_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] threshold,
    output logic             reached
);

    logic [WIDTH-1:0] count;

    // The count sticks at all-ones so a state held longer than the counter
    // range still sees "reached" instead of wrapping back below threshold.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign reached = (count >= threshold);

endmodule

// File: rtl/irrigation_actuator_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// irrigation_actuator_sequencer
// Registered output stage between the irrigation decision logic and the
// physical actuators. Enforces minimum on/off times, mutual exclusion of
// sprinkler and dripper, and a latched alarm lockout with a hold period.
//   clock                 : system clock
//   reset_n               : synchronous active-low reset
//   alarm                 : water-level sensor inconsistency flag
//   water_supply_valvule  : supply-valve request
//   splinker_bomb         : sprinkler-pump request
//   dripper_valvule       : dripper-valve request
//   supply_valve_drive    : supply-valve actuator (registered request, gated)
//   sprinkler_pump_drive  : sprinkler-pump actuator
//   dripper_valve_drive   : dripper-valve actuator
//   alarm_latched         : high while in LOCKOUT
//   busy                  : high in any state other than IDLE
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module irrigation_actuator_sequencer
    import irrigation_pkg::*;
#(
    parameter int MIN_ON_CYCLES     = DEFAULT_MIN_ON_CYCLES,
    parameter int MIN_OFF_CYCLES    = DEFAULT_MIN_OFF_CYCLES,
    parameter int ALARM_HOLD_CYCLES = DEFAULT_ALARM_HOLD_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic alarm,
    input  logic water_supply_valvule,
    input  logic splinker_bomb,
    input  logic dripper_valvule,
    output logic supply_valve_drive,
    output logic sprinkler_pump_drive,
    output logic dripper_valve_drive,
    output logic alarm_latched,
    output logic busy
);

    localparam int CNT_W = dwell_width(MIN_ON_CYCLES, MIN_OFF_CYCLES, ALARM_HOLD_CYCLES);

    // On and off dwells count from 0 on state entry, so the last permitted
    // cycle sits at (cycles - 1). The lockout hold counts alarm-low samples,
    // so it compares against the full cycle count.
    localparam logic [CNT_W-1:0] ON_THRESHOLD   = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_THRESHOLD  = CNT_W'(MIN_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_THRESHOLD = CNT_W'(ALARM_HOLD_CYCLES);

    irr_state_t       state;
    irr_state_t       next_state;
    logic [CNT_W-1:0] threshold;
    logic             dwell_clear;
    logic             dwell_enable;
    logic             dwell_reached;

    // Pick the dwell limit that applies to the current state.
    always_comb begin
        threshold = '0;
        case (state)
            SPRINKLE, DRIP: threshold = ON_THRESHOLD;
            GAP:            threshold = OFF_THRESHOLD;
            LOCKOUT:        threshold = HOLD_THRESHOLD;
            default:        threshold = '0;
        endcase
    end

    // Next-state decision. Alarm overrides every dwell; sprinkler wins over
    // dripper whenever both are requested from a resting state; SPRINKLE and
    // DRIP only ever leave through GAP so the two drives can never touch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (alarm)                next_state = LOCKOUT;
                else if (splinker_bomb)   next_state = SPRINKLE;
                else if (dripper_valvule) next_state = DRIP;
            end
            SPRINKLE: begin
                if (alarm)                                 next_state = LOCKOUT;
                else if (dwell_reached && !splinker_bomb)  next_state = GAP;
            end
            DRIP: begin
                if (alarm)                                  next_state = LOCKOUT;
                else if (dwell_reached && !dripper_valvule) next_state = GAP;
            end
            GAP: begin
                if (alarm) begin
                    next_state = LOCKOUT;
                end else if (dwell_reached) begin
                    if (splinker_bomb)        next_state = SPRINKLE;
                    else if (dripper_valvule) next_state = DRIP;
                    else                      next_state = IDLE;
                end
            end
            LOCKOUT: begin
                if (!alarm && dwell_reached) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The dwell counter restarts on every state change. Inside LOCKOUT it is
    // also held at zero while alarm is high, so a re-assertion restarts the
    // hold. It sits idle in IDLE, where no dwell applies.
    assign dwell_clear  = (next_state != state) || ((state == LOCKOUT) && alarm);
    assign dwell_enable = (state != IDLE);

    dwell_counter #(
        .WIDTH(CNT_W)
    ) u_dwell_counter (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (dwell_clear),
        .enable    (dwell_enable),
        .threshold (threshold),
        .reached   (dwell_reached)
    );

    // State register and output flops. Outputs are decoded from the state
    // being entered so every drive changes on the same edge as the state,
    // giving one cycle of latency with no combinational path to the pins.
    // The supply valve has no dwell, it is simply the request gated off
    // whenever alarm is sampled high or the lockout is active.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                <= IDLE;
            supply_valve_drive   <= 1'b0;
            sprinkler_pump_drive <= 1'b0;
            dripper_valve_drive  <= 1'b0;
            alarm_latched        <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            state                <= next_state;
            supply_valve_drive   <= water_supply_valvule && !alarm && (next_state != LOCKOUT);
            sprinkler_pump_drive <= (next_state == SPRINKLE);
            dripper_valve_drive  <= (next_state == DRIP);
            alarm_latched        <= (next_state == LOCKOUT);
            busy                 <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_irrigation_actuator_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_irrigation_actuator_sequencer
// Drives three sequencer instances (default timing, all-ones timing, and a
// long 255-cycle on-time) from shared inputs. Every cycle each instance is
// compared against a behavioural model that tracks pulse lengths, gap lengths
// and alarm-low streaks directly. Directed vectors and sequences add
// hand-derived expectations for the default and the short-timing instances.
// Output vectors are ordered {supply, sprinkler, dripper, alarm_latched, busy}.
// -----------------------------------------------------------------------------
module tb_irrigation_actuator_sequencer;

    logic clock;
    logic reset_n;
    logic alarm;
    logic water_supply_valvule;
    logic splinker_bomb;
    logic dripper_valvule;

    logic [4:0] def_out;
    logic [4:0] min_out;
    logic [4:0] sat_out;

    int total;
    int bad;

    // Behavioural reference state: which actuator is on and for how long,
    // how long the current gap has lasted, and the alarm-low streak.
    typedef struct {
        bit       lock;
        int       low_seen;
        int       act;
        int       on_len;
        bit       in_gap;
        int       gap_len;
        bit [4:0] out;
    } model_t;

    typedef struct {
        bit       rn;
        bit       al;
        bit       sup;
        bit       sp;
        bit       dr;
        bit [4:0] exp;
    } vec_t;

    model_t mdl [3];
    int     p_on   [3] = '{8, 1, 255};
    int     p_off  [3] = '{4, 1, 4};
    int     p_hold [3] = '{16, 1, 16};
    vec_t   vecs [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    irrigation_actuator_sequencer dut_def (
        .clock                (clock),
        .reset_n              (reset_n),
        .alarm                (alarm),
        .water_supply_valvule (water_supply_valvule),
        .splinker_bomb        (splinker_bomb),
        .dripper_valvule      (dripper_valvule),
        .supply_valve_drive   (def_out[4]),
        .sprinkler_pump_drive (def_out[3]),
        .dripper_valve_drive  (def_out[2]),
        .alarm_latched        (def_out[1]),
        .busy                 (def_out[0])
    );

    irrigation_actuator_sequencer #(
        .MIN_ON_CYCLES     (1),
        .MIN_OFF_CYCLES    (1),
        .ALARM_HOLD_CYCLES (1)
    ) dut_min (
        .clock                (clock),
        .reset_n              (reset_n),
        .alarm                (alarm),
        .water_supply_valvule (water_supply_valvule),
        .splinker_bomb        (splinker_bomb),
        .dripper_valvule      (dripper_valvule),
        .supply_valve_drive   (min_out[4]),
        .sprinkler_pump_drive (min_out[3]),
        .dripper_valve_drive  (min_out[2]),
        .alarm_latched        (min_out[1]),
        .busy                 (min_out[0])
    );

    irrigation_actuator_sequencer #(
        .MIN_ON_CYCLES     (255),
        .MIN_OFF_CYCLES    (4),
        .ALARM_HOLD_CYCLES (16)
    ) dut_sat (
        .clock                (clock),
        .reset_n              (reset_n),
        .alarm                (alarm),
        .water_supply_valvule (water_supply_valvule),
        .splinker_bomb        (splinker_bomb),
        .dripper_valvule      (dripper_valvule),
        .supply_valve_drive   (sat_out[4]),
        .sprinkler_pump_drive (sat_out[3]),
        .dripper_valve_drive  (sat_out[2]),
        .alarm_latched        (sat_out[1]),
        .busy                 (sat_out[0])
    );

    // One clock edge of the reference model, written from the behavioural
    // rules: a drive stays on until it has been high on_c cycles and its
    // request is gone, a gap lasts off_c low cycles, and the lockout ends one
    // edge after hold_c consecutive alarm-low samples.
    function automatic model_t model_step(input model_t m, input int on_c, input int off_c,
                                          input int hold_c, input bit rn, input bit al,
                                          input bit sup, input bit sp, input bit dr);
        model_t n;
        bit     own_req;
        n = m;
        if (!rn) begin
            n.lock = 0; n.low_seen = 0; n.act = 0; n.on_len = 0;
            n.in_gap = 0; n.gap_len = 0; n.out = '0;
            return n;
        end
        if (al) begin
            n.lock = 1; n.low_seen = 0; n.act = 0; n.in_gap = 0;
        end else if (n.lock) begin
            if (n.low_seen >= hold_c) n.lock = 0;
            else n.low_seen = n.low_seen + 1;
        end else if (n.act != 0) begin
            own_req = (n.act == 1) ? sp : dr;
            if (n.on_len >= on_c && !own_req) begin
                n.act = 0; n.in_gap = 1; n.gap_len = 1;
            end else begin
                n.on_len = n.on_len + 1;
            end
        end else if (n.in_gap && n.gap_len < off_c) begin
            n.gap_len = n.gap_len + 1;
        end else begin
            n.in_gap = 0;
            if (sp) begin
                n.act = 1; n.on_len = 1;
            end else if (dr) begin
                n.act = 2; n.on_len = 1;
            end
        end
        n.out = {sup && !al && !n.lock, n.act == 1, n.act == 2, n.lock,
                 n.lock || (n.act != 0) || n.in_gap};
        return n;
    endfunction

    function automatic void add_vec(input bit rn, input bit al, input bit sup,
                                    input bit sp, input bit dr, input bit [4:0] exp);
        vec_t v;
        v.rn = rn; v.al = al; v.sup = sup; v.sp = sp; v.dr = dr; v.exp = exp;
        vecs.push_back(v);
    endfunction

    // Single comparison: counts it, and reports a mismatch on one line.
    task automatic checkOutput(input string name, input logic [4:0] actual,
                               input logic [4:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %b expected %b (supply,spr,drip,latched,busy) at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance all models on the edge, then sample
    // every instance 1 ns after the edge against its model.
    task automatic applyStimulus(input bit rn, input bit al, input bit sup,
                                 input bit sp, input bit dr);
        reset_n              = rn;
        alarm                = al;
        water_supply_valvule = sup;
        splinker_bomb        = sp;
        dripper_valvule      = dr;
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            mdl[k] = model_step(mdl[k], p_on[k], p_off[k], p_hold[k], rn, al, sup, sp, dr);
        end
        #1;
        checkOutput("model_def", def_out, mdl[0].out);
        checkOutput("model_min", min_out, mdl[1].out);
        checkOutput("model_sat", sat_out, mdl[2].out);
    endtask

    initial begin
        bit r_rn, r_al, r_sup, r_sp, r_dr;
        total = 0;
        bad   = 0;
        for (int k = 0; k < 3; k++) mdl[k] = model_step(mdl[k], 1, 1, 1, 0, 0, 0, 0, 0);

        // Default-timing vectors: reset, 1-cycle sprinkler pulse, supply
        // follow, then both requests held with the sprinkler dropped later.
        add_vec(0, 0, 0, 0, 0, 5'b00000);
        add_vec(1, 0, 0, 1, 0, 5'b01001);
        for (int i = 0; i < 7; i++) add_vec(1, 0, 0, 0, 0, 5'b01001);
        for (int i = 0; i < 4; i++) add_vec(1, 0, 0, 0, 0, 5'b00001);
        add_vec(1, 0, 0, 0, 0, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            add_vec(1, 0, 1, 0, 0, 5'b10000);
            add_vec(1, 0, 0, 0, 0, 5'b00000);
        end
        for (int i = 0; i < 10; i++) add_vec(1, 0, 0, 1, 1, 5'b01001);
        for (int i = 0; i < 4; i++) add_vec(1, 0, 0, 0, 1, 5'b00001);
        add_vec(1, 0, 0, 0, 1, 5'b00101);
        for (int i = 0; i < 7; i++) add_vec(1, 0, 0, 0, 0, 5'b00101);
        for (int i = 0; i < 4; i++) add_vec(1, 0, 0, 0, 0, 5'b00001);
        add_vec(1, 0, 0, 0, 0, 5'b00000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rn, vecs[i].al, vecs[i].sup, vecs[i].sp, vecs[i].dr);
            checkOutput($sformatf("vec%0d", i), def_out, vecs[i].exp);
        end

        // Reset while the sprinkler is at dwell 3, then the request held.
        applyStimulus(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("reset_mid_sprinkle", def_out, 5'b00000);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("sprinkle_after_reset", def_out, 5'b01001);
        for (int i = 0; i < 13; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("idle_after_reset_seq", def_out, 5'b00000);

        // Alarm at dwell 3 of DRIP, a short re-assertion, then the full hold.
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("drip_engage", def_out, 5'b00101);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("alarm_entry", def_out, 5'b00011);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 1, 0, 0);
            checkOutput($sformatf("lock_first_low%0d", i), def_out, 5'b00011);
        end
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("alarm_reassert", def_out, 5'b00011);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 1, 1, 0);
            checkOutput($sformatf("lock_hold%0d", i), def_out, 5'b00011);
        end
        applyStimulus(1, 0, 1, 1, 0);
        checkOutput("lock_release_idle", def_out, 5'b10000);
        applyStimulus(1, 0, 1, 1, 0);
        checkOutput("sprinkle_after_lock", def_out, 5'b11001);
        for (int i = 0; i < 14; i++) applyStimulus(1, 0, 0, 0, 0);

        // Shortest timing: 1-cycle pulse, 1-cycle gap, 1-cycle hold.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("min_pulse", min_out, 5'b01001);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("min_gap", min_out, 5'b00001);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("min_idle", min_out, 5'b00000);
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("min_lock", min_out, 5'b00011);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("min_hold", min_out, 5'b00011);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("min_unlock", min_out, 5'b00000);

        // Hold the sprinkler well past the 9-bit counter range of the long
        // instance; release must still go straight to GAP.
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) applyStimulus(1, 0, 0, 1, 0);
        checkOutput("sat_held", sat_out, 5'b01001);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("sat_release", sat_out, 5'b00001);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0);

        // Randomised traffic with sticky requests and rare alarm/reset.
        r_sp = 0;
        r_dr = 0;
        for (int i = 0; i < 3000; i++) begin
            r_rn  = ($urandom_range(0, 149) != 0);
            r_al  = ($urandom_range(0, 59) == 0);
            r_sup = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) r_sp = ~r_sp;
            if ($urandom_range(0, 5) == 0) r_dr = ~r_dr;
            applyStimulus(r_rn, r_al, r_sup, r_sp, r_dr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
